dct_out_wr_ctrl: RTL
====================

DCT_OUT_WR_CTRL -- requirements
Module: dct_out_wr_ctrl

Interface
REQ-001 SHALL have parameter DW, default 192, DCT output word width (16 coefficients x 12 bits).
REQ-002 SHALL have parameter AW, default 14, output-memory address width (RA 10 bits, CA 4 bits).
REQ-003 SHALL have parameter LATENCY, default 17, cycles from start to the first valid DCT word; range 0..255.
REQ-004 SHALL have parameter NWORDS, default 16384, words written per frame; range 1..2^AW.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous and active-high.
REQ-007 SHALL have port start, input, 1, one-cycle frame start request.
REQ-008 SHALL have port en, input, 1, DCT output valid for the current cycle.
REQ-009 SHALL have port x_k_in, input, DW, DCT coefficient word.
REQ-010 SHALL have port d_out, output, DW, registered write data to the output memory.
REQ-011 SHALL have port ra_out, output, 10, registered row address, equal to address bits [13:4].
REQ-012 SHALL have port ca_out, output, 4, registered column address, equal to address bits [3:0].
REQ-013 SHALL have port nwrt_out, output, 1, active-low write strobe, registered.
REQ-014 SHALL have port nce_out, output, 1, active-low chip enable, registered.
REQ-015 SHALL have port busy, output, 1, high in SKIP and WRITE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the last word of a frame is written.
REQ-017 SHALL have port wr_count, output, AW, number of words written in the current frame.

Function
REQ-018 SHALL implement the FSM states IDLE, SKIP, WRITE and DONE.
REQ-019 IDLE: start=1 SHALL move to SKIP with skip_cnt=LATENCY, or directly to WRITE if LATENCY=0; wr_addr and wr_count SHALL clear to 0.
REQ-020 SKIP: skip_cnt SHALL decrement each cycle; at skip_cnt=1 the FSM SHALL enter WRITE on the next edge; en and x_k_in SHALL be ignored in SKIP.
REQ-021 WRITE with en=1: on the next edge d_out<=x_k_in, {ra_out,ca_out}<=wr_addr, nwrt_out<=0 and nce_out<=0, and wr_addr and wr_count SHALL increment.
REQ-022 WRITE with en=0: on the next edge nwrt_out<=1 and nce_out<=1, and wr_addr, d_out and addresses SHALL hold.
REQ-023 Latency SHALL be exactly 1 cycle from the x_k_in sample to the matching strobe, data and address.
REQ-024 When the word at wr_addr=NWORDS-1 is accepted, the FSM SHALL enter DONE on that edge; wr_addr SHALL wrap to 0 and never exceed NWORDS-1.
REQ-025 DONE: done=1 and nce_out=nwrt_out=1 for exactly one cycle, then the FSM SHALL enter IDLE; wr_count SHALL hold NWORDS mod 2^AW until the next start.
REQ-026 start asserted in SKIP, WRITE or DONE SHALL be ignored, with no restart and no queueing.
REQ-027 In IDLE, SKIP and DONE, nwrt_out and nce_out SHALL both be 1.
REQ-028 nwrt_out=0 SHALL never occur while nce_out=1.

Reset
REQ-029 When reset=1 at a clock edge, the block SHALL go to IDLE regardless of state, including mid-frame with no partial-frame done.
REQ-030 Reset SHALL drive d_out=0, ra_out=0, ca_out=0, nwrt_out=1, nce_out=1, busy=0, done=0, wr_count=0, skip_cnt=0 and wr_addr=0.
REQ-031 Reset SHALL take priority over start and en in the same cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the DW/AW defaults, and the RA width 10 / CA width 4 constants.
REQ-033 A single sub-module, wr_addr_counter (AW-bit counter with clear, increment, terminal-count flag at NWORDS-1, and wrap), SHALL generate wr_addr; the FSM and output registers SHALL stay in dct_out_wr_ctrl.

Verification
REQ-034 Scenario 1 -- reset held 3 cycles with start=1, en=1 -> outputs equal the REQ-030 values; busy stays 0.
REQ-035 Scenario 2 -- LATENCY=17: start at cycle 0, en=1 throughout, x_k_in=cycle index -> first nwrt_out=0 at cycle 19 with d_out=18 and ra/ca=0/0.
REQ-036 Scenario 3 -- NWORDS=16384, en=1 continuous -> addresses 0..16383 are written in order; ra_out=1023 and ca_out=15 on the last write; done pulses once on the following cycle; wr_count=0 (wrapped).
REQ-037 Scenario 4 -- en toggling 1,0,0,1 in WRITE -> exactly 2 writes at consecutive addresses; nce_out=nwrt_out=1 during the gaps; address holds.
REQ-038 Scenario 5 -- reset pulsed at word 100 -> IDLE next cycle with no done; a new start rewrites from address 0.
REQ-039 Scenario 6 -- NWORDS=4, LATENCY=0, start repeated while busy -> exactly 4 writes and 1 done; the extra start is ignored.

Source files
------------

// File: rtl/dct_out_wr_ctrl_pkg.sv
// Shared definitions for the DCT output write controller: state encoding,
// default widths and the row/column split of the output-memory address.
package dct_out_wr_ctrl_pkg;

    localparam int DW_DEF = 192;
    localparam int AW_DEF = 14;
    localparam int RA_W   = 10;
    localparam int CA_W   = 4;
    localparam int SKIP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dct_out_wr_ctrl_addr_counter.sv
// Write-address generator: clears on frame start, advances per accepted word,
// flags the last address of the frame and wraps back to zero after it.
module wr_addr_counter
    import dct_out_wr_ctrl_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int NWORDS = 16384
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic          tc_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    // Next address: clear wins over increment; increment wraps at the last address
    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = {AW{1'b0}};
        end else if (inc_i) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = {AW{1'b0}};
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Address register
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= {AW{1'b0}};
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign tc_o   = (addr_q == LAST_ADDR);

endmodule

// File: rtl/dct_out_wr_ctrl.sv
// Writes one frame of DCT output words into the output memory: waits out the
// transform latency, then stores each valid word with registered strobes.
module dct_out_wr_ctrl
    import dct_out_wr_ctrl_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int LATENCY = 17,
    parameter int NWORDS  = 16384
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            en,
    input  logic [DW-1:0]   x_k_in,
    output logic [DW-1:0]   d_out,
    output logic [RA_W-1:0] ra_out,
    output logic [CA_W-1:0] ca_out,
    output logic            nwrt_out,
    output logic            nce_out,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   wr_count
);

    localparam int MA_W = RA_W + CA_W;

    state_e              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [DW-1:0]       data_q, data_d;
    logic [MA_W-1:0]     maddr_q, maddr_d;
    logic                nwrt_q, nwrt_d;
    logic                nce_q, nce_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [AW-1:0]       cnt_q, cnt_d;

    logic                ctr_clr_s;
    logic                ctr_inc_s;
    logic [AW-1:0]       wr_addr_s;
    logic                ctr_tc_s;

    wr_addr_counter #(
        .AW     (AW),
        .NWORDS (NWORDS)
    ) u_wr_addr_counter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (ctr_clr_s),
        .inc_i  (ctr_inc_s),
        .addr_o (wr_addr_s),
        .tc_o   (ctr_tc_s)
    );

    // Next-state and output-register logic; strobes default to inactive
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        data_d    = data_q;
        maddr_d   = maddr_q;
        nwrt_d    = 1'b1;
        nce_d     = 1'b1;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        ctr_clr_s = 1'b0;
        ctr_inc_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctr_clr_s = 1'b1;
                    cnt_d     = {AW{1'b0}};
                    if (LATENCY == 0) begin
                        skip_d  = {SKIP_W{1'b0}};
                        state_d = ST_WRITE;
                    end else begin
                        skip_d  = SKIP_W'(LATENCY);
                        state_d = ST_SKIP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SKIP: begin
                skip_d = skip_q - 8'd1;
                if (skip_q <= 8'd1) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_SKIP;
                end
            end
            ST_WRITE: begin
                if (en) begin
                    data_d    = x_k_in;
                    maddr_d   = MA_W'(wr_addr_s);
                    nwrt_d    = 1'b0;
                    nce_d     = 1'b0;
                    ctr_inc_s = 1'b1;
                    cnt_d     = cnt_q + AW'(1);
                    if (ctr_tc_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SKIP) || (state_d == ST_WRITE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= {SKIP_W{1'b0}};
            data_q  <= {DW{1'b0}};
            maddr_q <= {MA_W{1'b0}};
            nwrt_q  <= 1'b1;
            nce_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            data_q  <= data_d;
            maddr_q <= maddr_d;
            nwrt_q  <= nwrt_d;
            nce_q   <= nce_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d_out    = data_q;
    assign ra_out   = maddr_q[MA_W-1:CA_W];
    assign ca_out   = maddr_q[CA_W-1:0];
    assign nwrt_out = nwrt_q;
    assign nce_out  = nce_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = cnt_q;

endmodule
